// File: rtl/io_bus_master_pkg.sv
// rtl/io_bus_master_pkg.sv - shared bus encodings and widths for the peripheral I/O bus
package io_bus_master_pkg;

  // bus_ctrl encodings seen by every peripheral
  localparam logic IO_CTRL_WRITE = 1'b1;
  localparam logic IO_CTRL_READ  = 1'b0;

  // Default bus geometry
  localparam int DATABUS   = 16;
  localparam int ADDRBUS   = 16;
  localparam int CPU_WIDTH = 16;

  // Width of the wait-state counter; WAIT_STATES is limited to 0..15
  localparam int WAIT_W = 4;

endpackage

// File: rtl/io_wait_counter.sv
// rtl/io_wait_counter.sv - loadable down-counter with zero flag for read wait states
module io_wait_counter
  import io_bus_master_pkg::*;
#(
  parameter int W = WAIT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load takes priority; decrement saturates at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/io_bus_master.sv
// rtl/io_bus_master.sv - CPU-side initiator turning single/burst requests into I/O bus cycles
module io_bus_master
  import io_bus_master_pkg::*;
#(
  parameter int DATA_W      = DATABUS,
  parameter int ADDR_W      = ADDRBUS,
  parameter int LEN_W       = 3,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic              incr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  output logic              ready,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wvalid,
  output logic              wready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              done,
  output logic              bus_en,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_ctrl,
  inout  wire  [DATA_W-1:0] bus_data
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              we_q, we_d;
  logic              incr_q, incr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  beats_q, beats_d;
  logic [DATA_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              wait_zero;

  // Wait states are reloaded every SETUP cycle and consumed during read ACCESS
  io_wait_counter #(.W(WAIT_W)) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state_q == S_SETUP),
    .load_val (WAIT_W'(WAIT_STATES)),
    .dec      (state_q == S_ACCESS),
    .zero     (wait_zero)
  );

  // Beat sequencing: accept, per-beat setup/access, address stepping and read capture
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    incr_d   = incr_q;
    addr_d   = addr_q;
    beats_d  = beats_q;
    wreg_d   = wreg_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          incr_d  = incr;
          addr_d  = addr;
          beats_d = (len == '0) ? LEN_W'(1) : len;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (!we_q) begin
          state_d = S_ACCESS;
        end else if (wvalid) begin
          wreg_d  = wdata;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // Writes always leave after one granted cycle; reads wait out the counter
        if (we_q || wait_zero) begin
          if (!we_q) begin
            rdata_d  = bus_data;
            rvalid_d = 1'b1;
          end
          beats_d = beats_q - 1'b1;
          if (beats_q == LEN_W'(1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SETUP;
            if (incr_q) begin
              addr_d = addr_q + 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      incr_q   <= 1'b0;
      addr_q   <= '0;
      beats_q  <= '0;
      wreg_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      incr_q   <= incr_d;
      addr_q   <= addr_d;
      beats_q  <= beats_d;
      wreg_q   <= wreg_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign ready    = (state_q == S_IDLE);
  assign wready   = (state_q == S_SETUP) && we_q;
  assign done     = (state_q == S_DONE);
  assign bus_en   = (state_q == S_ACCESS);
  assign bus_addr = addr_q;
  assign bus_ctrl = we_q ? IO_CTRL_WRITE : IO_CTRL_READ;
  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;
  // bus_en derives from the async-reset state, so the bus is released as soon as rst_n falls
  assign bus_data = (bus_en && we_q) ? wreg_q : 'z;

endmodule
